// File: rtl/led_sched_pkg.sv
// Shared constants and helpers for the LED rate scheduler: pattern modes,
// per-pair half-periods in base ticks, and the reload pattern for each mode.
package led_sched_pkg;

    typedef enum logic [1:0] {
        MODE_PAIRS = 2'd0,
        MODE_SAME  = 2'd1,
        MODE_CHASE = 2'd2,
        MODE_OFF   = 2'd3
    } mode_t;

    localparam int NPAIR = 4;
    localparam int CW    = 4;

    // Half-periods in 1/24 s ticks: pair 0..3 blink at 1, 2, 3, 4 Hz.
    localparam logic [NPAIR-1:0][CW-1:0] HALF_PER = {4'd3, 4'd4, 4'd6, 4'd12};

    localparam logic [CW-1:0] SAME_STEP  = 4'd12;
    localparam logic [CW-1:0] CHASE_STEP = 4'd6;

    localparam logic [7:0] RELOAD_PAIRS = 8'hFF;
    localparam logic [7:0] RELOAD_SAME  = 8'hFF;
    localparam logic [7:0] RELOAD_CHASE = 8'h03;
    localparam logic [7:0] RELOAD_OFF   = 8'h00;

    function automatic logic [7:0] reload_pat(input mode_t m);
        case (m)
            MODE_PAIRS: return RELOAD_PAIRS;
            MODE_SAME:  return RELOAD_SAME;
            MODE_CHASE: return RELOAD_CHASE;
            default:    return RELOAD_OFF;
        endcase
    endfunction

    function automatic mode_t mode_next(input mode_t m);
        case (m)
            MODE_PAIRS: return MODE_SAME;
            MODE_SAME:  return MODE_CHASE;
            MODE_CHASE: return MODE_OFF;
            default:    return MODE_PAIRS;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioner: 2-FF synchronizer, stable-time debounce and a
// single-cycle press pulse on each accepted rising level.
module key_debounce #(
    parameter int DB_CYC = 2_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic press
);

    localparam int DW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DB_CYC - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [DW-1:0] cnt;

    // cnt counts consecutive samples that disagree with the accepted level;
    // the DB_CYC-th such sample is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                cnt   <= '0;
                level <= sync2;
                press <= sync2;
            end else begin
                cnt <= cnt + DW'(1);
            end
        end
    end

endmodule

// File: rtl/led_rate_sched.sv
// LED pattern scheduler: base-tick prescaler, per-pair blink counters and a
// button-stepped pattern mode driving four LED pairs.
//
// mode  | meaning
// PAIRS | each pair blinks at its own rate (1/2/3/4 Hz)
// SAME  | all LEDs blink together every 12 ticks
// CHASE | one lit pair walks upward every 6 ticks
// OFF   | all LEDs dark, ticks ignored
module led_rate_sched #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int TICK_CYC = 4_166_667,
    parameter int DB_CYC   = 2_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_mode,
    input  logic       en,
    output logic [7:0] out,
    output logic [1:0] mode
);
    import led_sched_pkg::*;

    if (CLK_HZ <= 0 || TICK_CYC < 1 || DB_CYC < 1) begin : g_bad_params
        $error("led_rate_sched: CLK_HZ, TICK_CYC and DB_CYC must be positive");
    end

    localparam int PW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYC - 1);

    logic                        press;
    logic                        tick;
    mode_t                       mode_q, mode_d;
    logic [PW-1:0]               presc_q, presc_d;
    logic [NPAIR-1:0][CW-1:0]    cnt_q, cnt_d;
    logic [7:0]                  out_q, out_d;

    key_debounce #(
        .DB_CYC (DB_CYC)
    ) u_key (
        .clk     (clk),
        .rst     (rst),
        .key_raw (key_mode),
        .press   (press)
    );

    assign tick = en && (presc_q == PRESC_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_PAIRS;
        end else begin
            mode_q <= mode_d;
        end
    end

    always_comb begin
        mode_d = mode_q;
        if (press) begin
            mode_d = mode_next(mode_q);
        end
    end

    // A press wins over a coincident tick: the tick is simply dropped.
    always_comb begin
        presc_d = presc_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        if (press) begin
            presc_d = '0;
            cnt_d   = '0;
            out_d   = reload_pat(mode_d);
        end else if (en) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (tick) begin
                case (mode_q)
                    MODE_PAIRS: begin
                        for (int k = 0; k < NPAIR; k++) begin
                            if (cnt_q[k] == HALF_PER[k] - 4'd1) begin
                                cnt_d[k]        = '0;
                                out_d[2*k +: 2] = ~out_q[2*k +: 2];
                            end else begin
                                cnt_d[k] = cnt_q[k] + 4'd1;
                            end
                        end
                    end
                    MODE_SAME: begin
                        if (cnt_q[0] == SAME_STEP - 4'd1) begin
                            cnt_d[0] = '0;
                            out_d    = ~out_q;
                        end else begin
                            cnt_d[0] = cnt_q[0] + 4'd1;
                        end
                    end
                    MODE_CHASE: begin
                        if (cnt_q[0] == CHASE_STEP - 4'd1) begin
                            cnt_d[0] = '0;
                            out_d    = {out_q[5:0], out_q[7:6]};
                        end else begin
                            cnt_d[0] = cnt_q[0] + 4'd1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            cnt_q   <= '0;
            out_q   <= RELOAD_PAIRS;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign out  = out_q;
    assign mode = mode_q;

endmodule

// File: tb/tb_led_rate_sched.sv
// Directed bench for led_rate_sched with a 4-cycle tick and 3-sample debounce.
module tb_led_rate_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_mode = 1'b0;
    logic       en = 1'b1;
    logic [7:0] out;
    logic [1:0] mode;
    int         tests = 0;
    int         failed = 0;

    led_rate_sched #(
        .CLK_HZ   (40),
        .TICK_CYC (4),
        .DB_CYC   (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_mode (key_mode),
        .en       (en),
        .out      (out),
        .mode     (mode)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // After return, time is edge E0+1; the next rising edge is E1.
    task automatic do_reset();
        rst = 1'b1;
        en = 1'b1;
        key_mode = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    // Press registers at the 6th edge after the call; returns 6 edges later
    // with the button released and its debounced level back at 0.
    task automatic press_key();
        key_mode = 1'b1;
        step(6);
        key_mode = 1'b0;
        step(6);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(3);
        tests++; if (out !== 8'hFF) begin failed++; $display("FAIL reset_out: got %h want ff", out); end
        tests++; if (mode !== 2'd0) begin failed++; $display("FAIL reset_mode: got %0d want 0", mode); end
        rst = 1'b0;
        step(1);
        tests++; if (out !== 8'hFF) begin failed++; $display("FAIL post_reset_out: got %h want ff", out); end
    endtask

    task automatic test_pairs();
        do_reset();
        step(11);
        tests++; if (out !== 8'hFF) begin failed++; $display("FAIL pairs_e11: got %h want ff", out); end
        step(1);
        tests++; if (out !== 8'h3F) begin failed++; $display("FAIL pairs_e12: got %h want 3f", out); end
        step(35);
        tests++; if (out !== 8'h33) begin failed++; $display("FAIL pairs_e47: got %h want 33", out); end
        step(1);
        tests++; if (out !== 8'hCC) begin failed++; $display("FAIL pairs_e48: got %h want cc", out); end
    endtask

    task automatic test_pause();
        do_reset();
        step(10);
        tests++; if (out !== 8'hFF) begin failed++; $display("FAIL pause_e10: got %h want ff", out); end
        en = 1'b0;
        step(20);
        tests++; if (out !== 8'hFF) begin failed++; $display("FAIL pause_frozen: got %h want ff", out); end
        en = 1'b1;
        step(1);
        tests++; if (out !== 8'hFF) begin failed++; $display("FAIL pause_e31: got %h want ff", out); end
        step(1);
        tests++; if (out !== 8'h3F) begin failed++; $display("FAIL pause_e32: got %h want 3f", out); end
    endtask

    task automatic test_debounce();
        do_reset();
        key_mode = 1'b1;
        step(2);
        key_mode = 1'b0;
        step(10);
        tests++; if (mode !== 2'd0) begin failed++; $display("FAIL glitch_mode: got %0d want 0", mode); end
        key_mode = 1'b1;
        step(5);
        tests++; if (mode !== 2'd0) begin failed++; $display("FAIL press_early_mode: got %0d want 0", mode); end
        tests++; if (out !== 8'h0F) begin failed++; $display("FAIL press_early_out: got %h want 0f", out); end
        step(1);
        tests++; if (mode !== 2'd1) begin failed++; $display("FAIL press_mode: got %0d want 1", mode); end
        tests++; if (out !== 8'hFF) begin failed++; $display("FAIL press_reload: got %h want ff", out); end
        step(2);
        key_mode = 1'b0;
        step(20);
        tests++; if (mode !== 2'd1) begin failed++; $display("FAIL single_press: got %0d want 1", mode); end
        step(25);
        tests++; if (out !== 8'hFF) begin failed++; $display("FAIL same_pre: got %h want ff", out); end
        step(1);
        tests++; if (out !== 8'h00) begin failed++; $display("FAIL same_toggle1: got %h want 00", out); end
        step(48);
        tests++; if (out !== 8'hFF) begin failed++; $display("FAIL same_toggle2: got %h want ff", out); end
    endtask

    // Continues from SAME mode left by test_debounce.
    task automatic test_chase_off();
        press_key();
        tests++; if (mode !== 2'd2) begin failed++; $display("FAIL chase_mode: got %0d want 2", mode); end
        tests++; if (out !== 8'h03) begin failed++; $display("FAIL chase_reload: got %h want 03", out); end
        step(17);
        tests++; if (out !== 8'h03) begin failed++; $display("FAIL chase_hold: got %h want 03", out); end
        step(1);
        tests++; if (out !== 8'h0C) begin failed++; $display("FAIL chase_step1: got %h want 0c", out); end
        step(24);
        tests++; if (out !== 8'h30) begin failed++; $display("FAIL chase_step2: got %h want 30", out); end
        step(24);
        tests++; if (out !== 8'hC0) begin failed++; $display("FAIL chase_step3: got %h want c0", out); end
        step(24);
        tests++; if (out !== 8'h03) begin failed++; $display("FAIL chase_wrap: got %h want 03", out); end
        press_key();
        tests++; if (mode !== 2'd3) begin failed++; $display("FAIL off_mode: got %0d want 3", mode); end
        tests++; if (out !== 8'h00) begin failed++; $display("FAIL off_out: got %h want 00", out); end
        step(100);
        tests++; if (out !== 8'h00) begin failed++; $display("FAIL off_hold: got %h want 00", out); end
        press_key();
        tests++; if (mode !== 2'd0) begin failed++; $display("FAIL wrap_mode: got %0d want 0", mode); end
        tests++; if (out !== 8'hFF) begin failed++; $display("FAIL wrap_out: got %h want ff", out); end
    endtask

    task automatic test_press_en_low();
        do_reset();
        en = 1'b0;
        press_key();
        tests++; if (mode !== 2'd1) begin failed++; $display("FAIL enlow_mode: got %0d want 1", mode); end
        step(60);
        tests++; if (out !== 8'hFF) begin failed++; $display("FAIL enlow_frozen: got %h want ff", out); end
        en = 1'b1;
        step(47);
        tests++; if (out !== 8'hFF) begin failed++; $display("FAIL enlow_pre: got %h want ff", out); end
        step(1);
        tests++; if (out !== 8'h00) begin failed++; $display("FAIL enlow_toggle: got %h want 00", out); end
    endtask

    task automatic test_press_on_tick();
        do_reset();
        step(6);
        key_mode = 1'b1;
        step(5);
        tests++; if (mode !== 2'd0) begin failed++; $display("FAIL ontick_pre_mode: got %0d want 0", mode); end
        step(1);
        tests++; if (mode !== 2'd1) begin failed++; $display("FAIL ontick_mode: got %0d want 1", mode); end
        tests++; if (out !== 8'hFF) begin failed++; $display("FAIL ontick_out: got %h want ff", out); end
        key_mode = 1'b0;
        step(47);
        tests++; if (out !== 8'hFF) begin failed++; $display("FAIL ontick_same_pre: got %h want ff", out); end
        step(1);
        tests++; if (out !== 8'h00) begin failed++; $display("FAIL ontick_same_tog: got %h want 00", out); end
    endtask

    task automatic test_rst_mid();
        do_reset();
        press_key();
        press_key();
        tests++; if (out !== 8'h03) begin failed++; $display("FAIL rstmid_chase: got %h want 03", out); end
        step(18);
        tests++; if (out !== 8'h0C) begin failed++; $display("FAIL rstmid_step: got %h want 0c", out); end
        #2;
        rst = 1'b1;
        #1;
        tests++; if (out !== 8'hFF) begin failed++; $display("FAIL rstmid_async_out: got %h want ff", out); end
        tests++; if (mode !== 2'd0) begin failed++; $display("FAIL rstmid_async_mode: got %0d want 0", mode); end
        step(2);
        rst = 1'b0;
        step(11);
        tests++; if (out !== 8'hFF) begin failed++; $display("FAIL rstmid_restart_pre: got %h want ff", out); end
        step(1);
        tests++; if (out !== 8'h3F) begin failed++; $display("FAIL rstmid_restart_tog: got %h want 3f", out); end
    endtask

    initial begin
        test_reset();
        test_pairs();
        test_pause();
        test_debounce();
        test_chase_off();
        test_press_en_low();
        test_press_on_tick();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/led_rate_sched.md
LED_RATE_SCHED -- requirements
Module: led_rate_sched

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, system clock frequency (documentation only).
REQ-002 SHALL have parameter TICK_CYC, default 4_166_667, clk cycles per base tick (1/24 s).
REQ-003 SHALL have parameter DB_CYC, default 2_000_000, debounce stable-time in clk cycles (20 ms).
REQ-004 SHALL have port clk  input  1  system clock, all logic rising-edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port key_mode  input  1  raw active-high pushbutton, asynchronous to clk.
REQ-007 SHALL have port en  input  1  run enable, synchronous, level.
REQ-008 SHALL have port out  output  8  LED drive, pair k = out[2k+1:2k], k=0..3.
REQ-009 SHALL have port mode  output  2  current pattern mode.

Function
REQ-010 SHALL run a prescaler 0..TICK_CYC-1 while en=1; tick is a 1-cycle pulse when it wraps.
REQ-011 SHALL hold prescaler, pair counters and out unchanged while en=0.
REQ-012 SHALL pass key_mode through a 2-FF synchronizer, then accept a new level only after DB_CYC consecutive identical synchronized samples.
REQ-013 SHALL produce press (1 cycle) on the rising edge of the debounced level; release generates nothing; holding generates one press.
REQ-014 SHALL keep mode 0..3: PAIRS=0, SAME=1, CHASE=2, OFF=3; press advances mode by 1, 3 wraps to 0.
REQ-015 SHALL, on the edge following press, update mode, clear prescaler and all pair counters, load out with the new mode's reload pattern; accepted regardless of en.
REQ-016 SHALL use reload patterns PAIRS 8'hFF, SAME 8'hFF, CHASE 8'h03, OFF 8'h00.
REQ-017 PAIRS: pair k toggles both bits every H[k] ticks, H = {12,6,4,3} for k = 0..3 (1, 2, 3, 4 Hz blink).
REQ-018 SAME: all 8 bits toggle together every 12 ticks.
REQ-019 CHASE: exactly one pair lit (2'b11), others 0; lit pair advances k→k+1 every 6 ticks, pair 3 wraps to pair 0.
REQ-020 OFF: out held at 8'h00; ticks ignored.
REQ-021 SHALL update out on the same edge the completing tick is registered (no extra latency beyond the counter wrap).
REQ-022 SHALL give press priority over a coincident tick: the tick is discarded, mode change per REQ-015.
REQ-023 Pair counters SHALL use minimal width (4 bits) and wrap to 0 on reaching H[k]-1.

Reset
REQ-024 On rst=1, out SHALL be 8'hFF, mode 0, prescaler, pair counters, debounce counter 0, debounced level 0, synchronizer 0.
REQ-025 rst SHALL act immediately, mid-pattern or mid-debounce; operation restarts in PAIRS from count 0 after release.

Structure
REQ-026 Shared package led_sched_pkg SHALL hold mode enum, H[] half-period constants, CHASE/SAME step constants, reload patterns.
REQ-027 Synchronizer+debounce+edge detect SHALL be sub-module key_debounce (params DB_CYC; ports clk, rst, key_raw, press).
REQ-028 Prescaler, pair counters, mode register and output logic SHALL reside in led_rate_sched.

Verification (TICK_CYC=4, DB_CYC=3)
REQ-029 Release reset, en=1 -> out=FF, mode=0; pair3 toggles at tick 3 (cycle 12), pair0 toggles first at tick 12 (cycle 48).
REQ-030 key_mode high 2 cycles -> no press, mode stays 0; high 8 cycles -> exactly one press, mode=1, out=FF, counters cleared.
REQ-031 Mode 2 -> out sequence 03, 0C, 30, C0, 03 at 6-tick intervals; further press -> mode 3, out=00 permanently; next press -> mode 0, out=FF.
REQ-032 en=0 for 20 cycles mid-PAIRS -> out and counters frozen; en=1 -> next toggle occurs exactly 20 cycles later than unpaused.
REQ-033 Press aligned to a tick cycle in mode 0 -> no toggle, mode=1, out=FF; rst pulse mid-CHASE -> out=FF, mode=0 asynchronously.
